// File: rtl/memwb_pkg.sv
// Shared types and constants for the memory/writeback stage.
// Access-width encodings match the execute stage's mem_width field.
package memwb_pkg;

   localparam int RW_DFLT      = 16;
   localparam int REGNO_DFLT   = 8;
   localparam int TIMEOUT_DFLT = 255;

   localparam logic MEM_WIDTH_WORD = 1'b0;
   localparam logic MEM_WIDTH_BYTE = 1'b1;

   typedef enum logic {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   // Byte-lane select for a 16-bit bus from access width and address LSB.
   function automatic logic [1:0] lane_sel(input logic width, input logic addr_lsb);
      if (width == MEM_WIDTH_BYTE)
         return addr_lsb ? 2'b10 : 2'b01;
      else
         return 2'b11;
   endfunction

endpackage

// File: rtl/memwb_if.sv
// Execute-bundle, writeback and data-bus signals of the memory/writeback stage.
// slave = the memwb stage itself; master = execute plus the data-bus slave.
interface memwb_if #(
   parameter int RW    = 16,
   parameter int REGNO = 8
) ();

   logic             submit;
   logic             ready;
   logic [RW-1:0]    data;
   logic [RW-1:0]    addr;
   logic [REGNO-1:0] reg_ie;
   logic             mem_access;
   logic             mem_we;
   logic             mem_width;

   logic [REGNO-1:0] wb_reg_ie;
   logic [RW-1:0]    wb_reg_data;

   logic             mem_req;
   logic             bus_we;
   logic [RW-2:0]    mem_addr;
   logic [1:0]       mem_sel;
   logic [RW-1:0]    mem_wdata;
   logic             mem_ack;
   logic [RW-1:0]    mem_rdata;
   logic             bus_err;

   modport slave (
      input  submit, data, addr, reg_ie, mem_access, mem_we, mem_width,
      input  mem_ack, mem_rdata,
      output ready, wb_reg_ie, wb_reg_data,
      output mem_req, bus_we, mem_addr, mem_sel, mem_wdata, bus_err
   );

   modport master (
      output submit, data, addr, reg_ie, mem_access, mem_we, mem_width,
      output mem_ack, mem_rdata,
      input  ready, wb_reg_ie, wb_reg_data,
      input  mem_req, bus_we, mem_addr, mem_sel, mem_wdata, bus_err
   );

endinterface

// File: rtl/memwb_mem_lane_align.sv
// Combinational byte-lane alignment: lane select, store-data replication, load-data extraction.
// Shared with the instruction fetch path, so it holds no state.
module mem_lane_align
   import memwb_pkg::*;
#(
   parameter int RW = 16
) (
   input  logic          width,
   input  logic          addr_lsb,
   input  logic [RW-1:0] wdata_in,
   input  logic [RW-1:0] rdata_in,
   output logic [1:0]    sel,
   output logic [RW-1:0] wdata_out,
   output logic [RW-1:0] rdata_out
);

   always_comb begin
      sel       = lane_sel(width, addr_lsb);
      wdata_out = wdata_in;
      rdata_out = rdata_in;
      if (width == MEM_WIDTH_BYTE) begin
         // Slave picks the lane via sel, so the byte goes on every lane.
         wdata_out = {(RW/8){wdata_in[7:0]}};
         rdata_out = RW'(addr_lsb ? rdata_in[RW-1:RW-8] : rdata_in[7:0]);
      end
   end

endmodule

// File: rtl/memwb.sv
// Final pipeline stage: same-cycle writeback of ALU results, req/ack bus transaction for loads/stores.
// Memory ops stall execute (ready low) until ack or timeout abort; loads write back in the ack cycle.
module memwb
   import memwb_pkg::*;
#(
   parameter int RW      = RW_DFLT,
   parameter int REGNO   = REGNO_DFLT,
   parameter int TIMEOUT = TIMEOUT_DFLT
) (
   input logic   i_clk,
   input logic   i_rst,
   memwb_if.slave stage
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t           state;
   state_t           state_nxt;

   logic [RW-1:0]    addr_q;
   logic [RW-1:0]    data_q;
   logic [REGNO-1:0] reg_ie_q;
   logic             we_q;
   logic             width_q;
   logic [CW-1:0]    wait_cnt;
   logic             bus_err_q;

   logic             mem_start;
   logic             timeout_hit;
   logic [RW-1:0]    rdata_al;

   assign mem_start   = (state == IDLE) && stage.submit && stage.mem_access;
   // Ack in the same cycle as the last allowed wait wins over the abort.
   assign timeout_hit = (TIMEOUT != 0) && (state == MEM_WAIT) && !stage.mem_ack &&
                        (wait_cnt == CW'(TIMEOUT - 1));

   mem_lane_align #(.RW(RW)) u_align (
      .width     (width_q),
      .addr_lsb  (addr_q[0]),
      .wdata_in  (data_q),
      .rdata_in  (stage.mem_rdata),
      .sel       (stage.mem_sel),
      .wdata_out (stage.mem_wdata),
      .rdata_out (rdata_al)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (mem_start) state_nxt = MEM_WAIT;
         MEM_WAIT: if (stage.mem_ack || timeout_hit) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stage.ready       = (state == IDLE);
      stage.mem_req     = (state == MEM_WAIT);
      stage.wb_reg_ie   = '0;
      stage.wb_reg_data = '0;
      case (state)
         IDLE: begin
            if (stage.submit && !stage.mem_access) begin
               stage.wb_reg_ie   = stage.reg_ie;
               stage.wb_reg_data = stage.data;
            end
         end
         MEM_WAIT: begin
            // A reset landing on the ack cycle still discards the load.
            if (stage.mem_ack && !we_q && !i_rst) begin
               stage.wb_reg_ie   = reg_ie_q;
               stage.wb_reg_data = rdata_al;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (mem_start) begin
         addr_q   <= stage.addr;
         data_q   <= stage.data;
         reg_ie_q <= stage.reg_ie;
         we_q     <= stage.mem_we;
         width_q  <= stage.mem_width;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= timeout_hit;
         if (state == MEM_WAIT && !stage.mem_ack && !timeout_hit)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
      end
   end

   assign stage.bus_we   = we_q;
   assign stage.mem_addr = addr_q[RW-1:1];
   assign stage.bus_err  = bus_err_q;

endmodule
